// File: rtl/mips_pkg.sv
// mips_pkg -- shared MIPS datapath definitions.
//   pcsrc_e          : next-PC source select encoding
//   RESET_PC_DEFAULT : PC value loaded on reset unless overridden
package mips_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,  // sequential fetch / computed address
        PCSRC_TARGET = 2'b01,  // latched branch target
        PCSRC_JUMP   = 2'b10,  // pseudo-direct jump
        PCSRC_HOLD   = 2'b11   // keep current PC
    } pcsrc_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if -- control/data bundle between the controller/datapath and pc_unit.
//   master : drives pc_write, pc_write_cond, zero, branch_ne, pc_source,
//            alu_result, target_write, imm, jidx; observes the results
//   slave  : pc_unit side; drives pc, target, branch_offset, pc_changed, fault
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    import mips_pkg::*;

    logic             pc_write;
    logic             pc_write_cond;
    logic             zero;
    logic             branch_ne;
    pcsrc_e           pc_source;
    logic [WIDTH-1:0] alu_result;
    logic             target_write;
    logic [15:0]      imm;
    logic [25:0]      jidx;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] branch_offset;
    logic             pc_changed;
    logic             fault;

    modport master (
        output pc_write, pc_write_cond, zero, branch_ne, pc_source,
               alu_result, target_write, imm, jidx,
        input  pc, target, branch_offset, pc_changed, fault
    );

    modport slave (
        input  pc_write, pc_write_cond, zero, branch_ne, pc_source,
               alu_result, target_write, imm, jidx,
        output pc, target, branch_offset, pc_changed, fault
    );

endinterface

// File: rtl/pc_unit_signext16.sv
// signext16 -- sign-extends a 16-bit immediate to 32 bits.
//   imm : 16-bit immediate (instruction bits [15:0])
//   ext : 32-bit sign-extended value
module signext16 (
    input  logic [15:0] imm,
    output logic [31:0] ext
);

    assign ext = {{16{imm[15]}}, imm};

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- multi-cycle MIPS program counter with branch target register.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : pc_unit_if.slave (update controls, ALU result, instruction
//              fields in; pc, target, branch_offset, pc_changed, fault out)
// Optional feature macro: PC_ALIGN_CHECK_EN -- suppresses loads of a
// misaligned PC and raises a sticky fault flag. Without it, loads are
// unmodified and fault is tied low.
module pc_unit
    import mips_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    logic             pc_en;
    logic             load_req;
    logic             do_load;
    logic [WIDTH-1:0] next_pc;
    logic [31:0]      imm_ext;

    signext16 u_signext16 (
        .imm (bus.imm),
        .ext (imm_ext)
    );

    assign bus.branch_offset = imm_ext << 2;

    // NOTE: every signal written here gets a default first so no latch is
    // inferred when a case arm or branch leaves it unassigned.
    always_comb begin
        next_pc = bus.pc;
        unique case (bus.pc_source)
            PCSRC_ALU:    next_pc = bus.alu_result;
            PCSRC_TARGET: next_pc = bus.target;  // pre-edge value, even if target_write is high
            PCSRC_JUMP:   next_pc = {bus.pc[WIDTH-1 -: 4], bus.jidx, 2'b00};
            PCSRC_HOLD:   next_pc = bus.pc;
            default:      next_pc = bus.pc;
        endcase
    end

    assign pc_en    = bus.pc_write | (bus.pc_write_cond & (bus.zero ^ bus.branch_ne));
    assign load_req = pc_en & (bus.pc_source != PCSRC_HOLD);

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic fault_q;

    assign misaligned = |next_pc[1:0];
    assign do_load    = load_req & ~misaligned;

    // Sticky: once a misaligned load is attempted, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            fault_q <= 1'b0;
        else if (load_req && misaligned)
            fault_q <= 1'b1;
    end

    assign bus.fault = fault_q;
`else
    assign do_load   = load_req;
    assign bus.fault = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values (the same-edge target/pc case depends on it).
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pc         <= RESET_PC;
            bus.target     <= '0;
            bus.pc_changed <= 1'b0;
        end else begin
            if (bus.target_write)
                bus.target <= bus.alu_result;
            if (do_load)
                bus.pc <= next_pc;
            bus.pc_changed <= do_load;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed self-checking bench for pc_unit.
// Expectations follow PC_ALIGN_CHECK_EN when the alignment case is reached.
module tb_pc_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.target_write  = 1'b0;
        bus.zero          = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_source     = PCSRC_ALU;
    endtask

    initial begin
        idle();
        bus.alu_result = 32'h0;
        bus.imm        = 16'h0;
        bus.jidx       = 26'h0;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_pc",         bus.pc,         32'h0000_0000);
        check("reset_target",     bus.target,     32'h0);
        check("reset_pc_changed", bus.pc_changed, 32'h0);
        check("reset_fault",      bus.fault,      32'h0);

        // Fetch
        bus.pc_write = 1'b1; bus.pc_source = PCSRC_ALU; bus.alu_result = 32'h0000_0004;
        tick();
        check("fetch_pc",         bus.pc,         32'h0000_0004);
        check("fetch_pc_changed", bus.pc_changed, 32'h1);
        idle();
        tick();
        check("idle_pc_changed",  bus.pc_changed, 32'h0);
        check("idle_pc",          bus.pc,         32'h0000_0004);

        // Branch taken (beq, zero=1)
        bus.target_write = 1'b1; bus.alu_result = 32'h0000_0040;
        tick();
        check("tgt_latch",        bus.target,     32'h0000_0040);
        check("tgt_latch_pc",     bus.pc,         32'h0000_0004);
        idle();
        bus.pc_write_cond = 1'b1; bus.zero = 1'b1; bus.branch_ne = 1'b0;
        bus.pc_source = PCSRC_TARGET;
        tick();
        check("beq_taken_pc",     bus.pc,         32'h0000_0040);
        check("beq_taken_chg",    bus.pc_changed, 32'h1);
        // bne with zero=1: not taken; target changed first so a load would show
        bus.target_write = 1'b1; bus.alu_result = 32'h0000_0100;
        bus.pc_write_cond = 1'b0;
        tick();
        bus.target_write = 1'b0;
        bus.pc_write_cond = 1'b1; bus.branch_ne = 1'b1;
        tick();
        check("bne_not_taken_pc", bus.pc,         32'h0000_0040);
        check("bne_not_taken_chg", bus.pc_changed, 32'h0);
        // bne with zero=0: taken
        bus.zero = 1'b0;
        tick();
        check("bne_taken_pc",     bus.pc,         32'h0000_0100);

        // HOLD ignores pc_write
        idle();
        bus.pc_write = 1'b1; bus.pc_source = PCSRC_HOLD; bus.alu_result = 32'h0000_0200;
        tick();
        check("hold_pc",          bus.pc,         32'h0000_0100);
        check("hold_pc_changed",  bus.pc_changed, 32'h0);

        // Jump within the 256 MB region
        bus.pc_source = PCSRC_ALU; bus.alu_result = 32'h1000_0008;
        tick();
        check("jump_setup_pc",    bus.pc,         32'h1000_0008);
        bus.pc_source = PCSRC_JUMP; bus.jidx = 26'h000_0010;
        tick();
        check("jump_pc",          bus.pc,         32'h1000_0040);
        bus.jidx = 26'h3FF_FFFF;
        tick();
        check("jump_no_carry_pc", bus.pc,         32'h1FFF_FFFC);

        // Branch offset (combinational)
        bus.imm = 16'hFFFF; #1;
        check("boff_ffff",        bus.branch_offset, 32'hFFFF_FFFC);
        bus.imm = 16'h0004; #1;
        check("boff_0004",        bus.branch_offset, 32'h0000_0010);
        bus.imm = 16'h8000; #1;
        check("boff_8000",        bus.branch_offset, 32'hFFFE_0000);
        bus.imm = 16'h7FFF; #1;
        check("boff_7fff",        bus.branch_offset, 32'h0001_FFFC);

        // Same edge: pc takes old target, target takes new alu_result
        idle();
        bus.target_write = 1'b1; bus.alu_result = 32'h0000_0040;
        tick();
        check("same_edge_setup",  bus.target,     32'h0000_0040);
        bus.alu_result = 32'h0000_0080; bus.pc_write = 1'b1; bus.pc_source = PCSRC_TARGET;
        tick();
        check("same_edge_pc",     bus.pc,         32'h0000_0040);
        check("same_edge_target", bus.target,     32'h0000_0080);

        // Reset priority over all writes
        rst = 1'b1; bus.alu_result = 32'h0000_0300; bus.pc_source = PCSRC_ALU;
        tick();
        rst = 1'b0;
        check("rst_prio_pc",      bus.pc,         32'h0000_0000);
        check("rst_prio_target",  bus.target,     32'h0);
        check("rst_prio_chg",     bus.pc_changed, 32'h0);

        // Alignment
        idle();
        bus.pc_write = 1'b1; bus.pc_source = PCSRC_ALU; bus.alu_result = 32'h0000_0006;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc",         bus.pc,         32'h0000_0000);
        check("align_chg",        bus.pc_changed, 32'h0);
        check("align_fault",      bus.fault,      32'h1);
        bus.alu_result = 32'h0000_0008;
        tick();
        check("align_ok_pc",      bus.pc,         32'h0000_0008);
        check("align_sticky",     bus.fault,      32'h1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("align_clear",      bus.fault,      32'h0);
`else
        check("align_pc",         bus.pc,         32'h0000_0006);
        check("align_chg",        bus.pc_changed, 32'h1);
        check("align_fault",      bus.fault,      32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
